// File: rtl/atm_session_ctrl_if.sv
// Front-end/back-end bundle for the ATM session controller: table config, card/PIN/op strobes in,
// registered balance, result and state out.
interface atm_session_ctrl_if #(
  parameter int ACC_W = 4,
  parameter int BAL_W = 32,
  parameter int PIN_W = 16
);
  logic             cfg_we;
  logic [ACC_W-1:0] cfg_addr;
  logic [BAL_W-1:0] cfg_balance;
  logic [PIN_W-1:0] cfg_pin;
  logic             card_valid;
  logic [ACC_W-1:0] acc_num;
  logic             pin_valid;
  logic [PIN_W-1:0] pin;
  logic             op_valid;
  logic [2:0]       op;
  logic [BAL_W-1:0] amount;
  logic [PIN_W-1:0] new_pin;
  logic [BAL_W-1:0] balance;
  logic             success;
  logic             done;
  logic [2:0]       err;
  logic [2:0]       state;

  modport master (
    output cfg_we, cfg_addr, cfg_balance, cfg_pin, card_valid, acc_num,
           pin_valid, pin, op_valid, op, amount, new_pin,
    input  balance, success, done, err, state
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_balance, cfg_pin, card_valid, acc_num,
           pin_valid, pin, op_valid, op, amount, new_pin,
    output balance, success, done, err, state
  );
endinterface

// File: rtl/atm_session_ctrl.sv
// ATM session FSM with on-chip balance/PIN table and lockout; PIN result 1 edge, op result 2 edges after strobe.
// No backpressure: off-state strobes are dropped. Optional inactivity timeout under SESSION_TIMEOUT_EN.
module atm_session_ctrl #(
  parameter int NUM_ACCOUNTS   = 10,
  parameter int ACC_W          = 4,
  parameter int BAL_W          = 32,
  parameter int PIN_W          = 16,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  atm_session_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE = 3'd0, AUTH = 3'd1, MENU = 3'd2, EXEC = 3'd3} state_t;

  localparam logic [2:0] ERR_OK = 3'd0, ERR_BAD_ACC = 3'd1, ERR_BAD_PIN = 3'd2, ERR_LOCKED = 3'd3,
                         ERR_INSUFF = 3'd4, ERR_OVERFLOW = 3'd5, ERR_BAD_OP = 3'd6, ERR_TIMEOUT = 3'd7;
  localparam logic [2:0] OP_BALANCE = 3'd1, OP_WITHDRAW = 3'd2, OP_DEPOSIT = 3'd3,
                         OP_CHANGE_PIN = 3'd4, OP_LOGOUT = 3'd5;
  localparam logic [ACC_W:0] NUM_ACC_L   = (ACC_W+1)'(NUM_ACCOUNTS);
  localparam logic [2:0]     MAX_TRIES_L = 3'(MAX_TRIES);

  // EXEC outcome, staged one edge so table and balance output commit together.
  typedef struct packed {
    logic             ok;
    logic [2:0]       err;
    logic             bal_we;
    logic             pin_we;
    logic [BAL_W-1:0] bal;
  } res_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [2:0]       op_q, op_d;
  logic [BAL_W-1:0] amount_q, amount_d;
  logic [PIN_W-1:0] new_pin_q, new_pin_d;
  logic [BAL_W-1:0] balance_q, balance_d;
  logic             success_q, success_d;
  logic             done_q, done_d;
  logic [2:0]       err_q, err_d;
  logic             pend_q, pend_d;
  res_t             res_q, res_d;

  logic [BAL_W-1:0]        bal_tab [NUM_ACCOUNTS];
  logic [PIN_W-1:0]        pin_tab [NUM_ACCOUNTS];
  logic [NUM_ACCOUNTS-1:0] lock_q;
  logic [2:0]              tries_q [NUM_ACCOUNTS];

  logic             cfg_hit, try_clr, try_inc, lock_set;
  logic [2:0]       tries_nxt;
  logic [BAL_W:0]   dep_sum;

`ifdef SESSION_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q;
  logic             tmo_fire;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    cfg_hit   = (state_q == IDLE) && bus.cfg_we && ({1'b0, bus.cfg_addr} < NUM_ACC_L);
    dep_sum   = {1'b0, balance_q} + {1'b0, amount_q};
    tries_nxt = tries_q[acc_q] + 3'd1;
    state_d   = state_q;
    acc_d     = acc_q;
    op_d      = op_q;
    amount_d  = amount_q;
    new_pin_d = new_pin_q;
    balance_d = balance_q;
    success_d = 1'b0;
    done_d    = 1'b0;
    err_d     = err_q;
    pend_d    = 1'b0;
    res_d     = res_q;
    try_clr   = 1'b0;
    try_inc   = 1'b0;
    lock_set  = 1'b0;
`ifdef SESSION_TIMEOUT_EN
    tmo_fire  = 1'b0;
`endif

    if (pend_q) begin
      done_d    = 1'b1;
      success_d = res_q.ok;
      err_d     = res_q.err;
      if (res_q.bal_we) balance_d = res_q.bal;
    end

    unique case (state_q)
      IDLE: begin
        // A pending LOGOUT result owns this cycle's done slot, so card_valid waits.
        if (bus.card_valid && !bus.cfg_we && !pend_q) begin
          if ({1'b0, bus.acc_num} >= NUM_ACC_L) begin
            done_d = 1'b1;
            err_d  = ERR_BAD_ACC;
          end else if (lock_q[bus.acc_num]) begin
            done_d = 1'b1;
            err_d  = ERR_LOCKED;
          end else begin
            acc_d   = bus.acc_num;
            state_d = AUTH;
          end
        end
      end
      AUTH: begin
        if (bus.pin_valid) begin
          done_d = 1'b1;
          if (bus.pin == pin_tab[acc_q]) begin
            try_clr   = 1'b1;
            balance_d = bal_tab[acc_q];
            success_d = 1'b1;
            err_d     = ERR_OK;
            state_d   = MENU;
          end else begin
            try_inc = 1'b1;
            if (tries_nxt >= MAX_TRIES_L) begin
              lock_set = 1'b1;
              err_d    = ERR_LOCKED;
              state_d  = IDLE;
            end else begin
              err_d = ERR_BAD_PIN;
            end
          end
        end
      end
      MENU: begin
        if (bus.op_valid && !pend_q) begin
          op_d      = bus.op;
          amount_d  = bus.amount;
          new_pin_d = bus.new_pin;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        pend_d  = 1'b1;
        res_d   = '0;
        state_d = (op_q == OP_LOGOUT) ? IDLE : MENU;
        unique case (op_q)
          OP_BALANCE:    res_d.ok = 1'b1;
          OP_WITHDRAW: begin
            if (amount_q > balance_q) res_d.err = ERR_INSUFF;
            else begin
              res_d.ok     = 1'b1;
              res_d.bal_we = 1'b1;
              res_d.bal    = balance_q - amount_q;
            end
          end
          OP_DEPOSIT: begin
            if (dep_sum[BAL_W]) res_d.err = ERR_OVERFLOW;
            else begin
              res_d.ok     = 1'b1;
              res_d.bal_we = 1'b1;
              res_d.bal    = dep_sum[BAL_W-1:0];
            end
          end
          OP_CHANGE_PIN: begin
            res_d.ok     = 1'b1;
            res_d.pin_we = 1'b1;
          end
          OP_LOGOUT:     res_d.ok = 1'b1;
          default:       res_d.err = ERR_BAD_OP;
        endcase
      end
      default: state_d = IDLE;
    endcase

`ifdef SESSION_TIMEOUT_EN
    if ((state_q == AUTH || state_q == MENU) && !bus.pin_valid && !bus.op_valid &&
        !pend_q && tmo_q == TMO_MAX) begin
      tmo_fire  = 1'b1;
      done_d    = 1'b1;
      success_d = 1'b0;
      err_d     = ERR_TIMEOUT;
      state_d   = IDLE;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      balance_q <= '0;
      success_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      balance_q <= balance_d;
      success_q <= success_d;
      done_q    <= done_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q     <= acc_d;
    op_q      <= op_d;
    amount_q  <= amount_d;
    new_pin_q <= new_pin_d;
    res_q     <= res_d;
  end

  // Table contents survive reset; only a write landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (cfg_hit) begin
        bal_tab[bus.cfg_addr] <= bus.cfg_balance;
        pin_tab[bus.cfg_addr] <= bus.cfg_pin;
      end
      if (pend_q && res_q.bal_we) bal_tab[acc_q] <= res_q.bal;
      if (pend_q && res_q.pin_we) pin_tab[acc_q] <= new_pin_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) tries_q[i] <= '0;
    end else if (cfg_hit) begin
      lock_q[bus.cfg_addr]  <= 1'b0;
      tries_q[bus.cfg_addr] <= '0;
    end else begin
      if (try_clr)  tries_q[acc_q] <= '0;
      if (try_inc)  tries_q[acc_q] <= tries_nxt;
      if (lock_set) lock_q[acc_q]  <= 1'b1;
    end
  end

`ifdef SESSION_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst || tmo_fire || !(state_q == AUTH || state_q == MENU) ||
        bus.pin_valid || bus.op_valid || state_d != state_q) tmo_q <= '0;
    else tmo_q <= tmo_q + 1'b1;
  end
`endif

  assign bus.balance = balance_q;
  assign bus.success = success_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// Scoreboarded bench for atm_session_ctrl: expected completions queued at stimulus, matched against observed done pulses.
module tb_atm_session_ctrl;

  localparam logic [2:0] BAL = 3'd1, WD = 3'd2, DEP = 3'd3, CHP = 3'd4, LOGOUT = 3'd5;
  localparam logic [2:0] S_IDLE = 3'd0, S_AUTH = 3'd1, S_MENU = 3'd2;

  typedef struct {
    logic        ok;
    logic [2:0]  err;
    logic [31:0] bal;
    logic [2:0]  st;
    int          cyc;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_edge = 0;
  int   checks = 0;
  int   errors = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];
  rec_t mon_r;

  atm_session_ctrl_if #(.ACC_W(4), .BAL_W(32), .PIN_W(16)) bus ();

  atm_session_ctrl #(
    .NUM_ACCOUNTS(10), .ACC_W(4), .BAL_W(32), .PIN_W(16),
    .MAX_TRIES(3), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      mon_r.ok  = bus.success;
      mon_r.err = bus.err;
      mon_r.bal = bus.balance;
      mon_r.st  = bus.state;
      mon_r.cyc = cyc;
      obs_q.push_back(mon_r);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic expect_done(input logic ok, input logic [2:0] e, input logic [31:0] b, input logic [2:0] s);
    rec_t r;
    r.ok = ok; r.err = e; r.bal = b; r.st = s; r.cyc = 0;
    exp_q.push_back(r);
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] b, input logic [15:0] p);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_balance = b; bus.cfg_pin = p;
    @(posedge clk); #1;
    bus.cfg_we = 1'b0; last_edge = cyc;
  endtask

  task automatic card(input logic [3:0] a);
    bus.card_valid = 1'b1; bus.acc_num = a;
    @(posedge clk); #1;
    bus.card_valid = 1'b0; last_edge = cyc;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    bus.pin_valid = 1'b1; bus.pin = p;
    @(posedge clk); #1;
    bus.pin_valid = 1'b0; last_edge = cyc;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [15:0] np);
    bus.op_valid = 1'b1; bus.op = o; bus.amount = a; bus.new_pin = np;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; last_edge = cyc;
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) begin
      if (obs_q.size() >= exp_q.size()) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_balance = 0; bus.cfg_pin = 0;
    bus.card_valid = 0; bus.acc_num = 0; bus.pin_valid = 0; bus.pin = 0;
    bus.op_valid = 0; bus.op = 0; bus.amount = 0; bus.new_pin = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", bus.state); end
    checks++; if (bus.balance !== 32'd0) begin errors++; $display("FAIL reset_balance: got %0h want 0", bus.balance); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", bus.done); end
    checks++; if (bus.success !== 1'b0) begin errors++; $display("FAIL reset_success: got %0b want 0", bus.success); end
    checks++; if (bus.err !== 3'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", bus.err); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_login();
    string tn = "login";
    rec_t e, o;
    cfg_write(4'd2, 32'd500, 16'h1234);
    card(4'd2);
    checks++; if (bus.state !== S_AUTH) begin errors++; $display("FAIL login_auth_state: got %0d want 1", bus.state); end
    expect_done(1'b1, 3'd0, 32'd500, S_MENU);
    enter_pin(16'h1234);
    settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

  task automatic test_withdraw();
    string tn = "withdraw";
    rec_t e, o;
    int op_edge;
    expect_done(1'b1, 3'd0, 32'd300, S_MENU);
    do_op(WD, 32'd200, 16'h0);
    op_edge = last_edge;
    settle();
    checks++;
    if (obs_q.size() == 0 || obs_q[0].cyc != op_edge + 2) begin
      errors++;
      $display("FAIL withdraw_latency: got done at edge %0d want edge %0d",
               (obs_q.size() == 0) ? -1 : obs_q[0].cyc, op_edge + 2);
    end
    expect_done(1'b0, 3'd4, 32'd300, S_MENU);
    do_op(WD, 32'd301, 16'h0); settle();
    expect_done(1'b1, 3'd0, 32'd300, S_MENU);
    do_op(WD, 32'd0, 16'h0); settle();
    expect_done(1'b1, 3'd0, 32'd300, S_MENU);
    do_op(BAL, 32'd0, 16'h0); settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

  task automatic test_ignored();
    string tn = "ignored";
    rec_t e, o;
    card(4'd7);
    enter_pin(16'h1234);
    cfg_write(4'd2, 32'd9999, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL ignored_no_done: got %0d done pulses want 0", obs_q.size()); end
    checks++; if (bus.state !== S_MENU) begin errors++; $display("FAIL ignored_state: got %0d want 2", bus.state); end
    obs_q.delete();
    expect_done(1'b1, 3'd0, 32'd300, S_IDLE);
    do_op(LOGOUT, 32'd0, 16'h0); settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

  task automatic test_deposit();
    string tn = "deposit";
    rec_t e, o;
    cfg_write(4'd5, 32'hFFFF_FFF0, 16'h5555);
    card(4'd5);
    expect_done(1'b1, 3'd0, 32'hFFFF_FFF0, S_MENU); enter_pin(16'h5555); settle();
    expect_done(1'b0, 3'd5, 32'hFFFF_FFF0, S_MENU); do_op(DEP, 32'h20, 16'h0); settle();
    expect_done(1'b1, 3'd0, 32'hFFFF_FFFF, S_MENU); do_op(DEP, 32'h0F, 16'h0); settle();
    expect_done(1'b0, 3'd6, 32'hFFFF_FFFF, S_MENU); do_op(3'd0, 32'h1, 16'h0); settle();
    expect_done(1'b0, 3'd6, 32'hFFFF_FFFF, S_MENU); do_op(3'd7, 32'h1, 16'h0); settle();
    expect_done(1'b1, 3'd0, 32'hFFFF_FFFF, S_MENU); do_op(DEP, 32'h0, 16'h0); settle();
    expect_done(1'b1, 3'd0, 32'hFFFF_FFFF, S_IDLE); do_op(LOGOUT, 32'h0, 16'h0); settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

  task automatic test_lockout();
    string tn = "lockout";
    rec_t e, o;
    cfg_write(4'd3, 32'd77, 16'hAAAA);
    card(4'd3);
    expect_done(1'b0, 3'd2, 32'hFFFF_FFFF, S_AUTH); enter_pin(16'h0001); settle();
    expect_done(1'b0, 3'd2, 32'hFFFF_FFFF, S_AUTH); enter_pin(16'h0002); settle();
    expect_done(1'b0, 3'd3, 32'hFFFF_FFFF, S_IDLE); enter_pin(16'h0003); settle();
    expect_done(1'b0, 3'd3, 32'hFFFF_FFFF, S_IDLE); card(4'd3); settle();
    cfg_write(4'd3, 32'd77, 16'hAAAA);
    card(4'd3);
    expect_done(1'b1, 3'd0, 32'd77, S_MENU); enter_pin(16'hAAAA); settle();
    expect_done(1'b1, 3'd0, 32'd77, S_IDLE); do_op(LOGOUT, 32'h0, 16'h0); settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

  task automatic test_change_pin();
    string tn = "change_pin";
    rec_t e, o;
    card(4'd2);
    expect_done(1'b1, 3'd0, 32'd300, S_MENU); enter_pin(16'h1234); settle();
    expect_done(1'b1, 3'd0, 32'd300, S_MENU); do_op(CHP, 32'h0, 16'hBEEF); settle();
    expect_done(1'b1, 3'd0, 32'd300, S_IDLE); do_op(LOGOUT, 32'h0, 16'h0); settle();
    card(4'd2);
    expect_done(1'b0, 3'd2, 32'd300, S_AUTH); enter_pin(16'h1234); settle();
    expect_done(1'b1, 3'd0, 32'd300, S_MENU); enter_pin(16'hBEEF); settle();
    expect_done(1'b1, 3'd0, 32'd300, S_IDLE); do_op(LOGOUT, 32'h0, 16'h0); settle();
    expect_done(1'b0, 3'd1, 32'd300, S_IDLE); card(4'd12); settle();
    // cfg_we and card_valid together: only the write happens
    bus.card_valid = 1'b1; bus.acc_num = 4'd12;
    cfg_write(4'd9, 32'd42, 16'h9999);
    bus.card_valid = 1'b0;
    card(4'd9);
    expect_done(1'b1, 3'd0, 32'd42, S_MENU); enter_pin(16'h9999); settle();
    expect_done(1'b1, 3'd0, 32'd42, S_IDLE); do_op(LOGOUT, 32'h0, 16'h0); settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    string tn = "reset_mid_exec";
    rec_t e, o;
    card(4'd9);
    expect_done(1'b1, 3'd0, 32'd42, S_MENU); enter_pin(16'h9999); settle();
    bus.op_valid = 1'b1; bus.op = DEP; bus.amount = 32'd100;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (bus.state !== S_IDLE) begin errors++; $display("FAIL rst_exec_state: got %0d want 0", bus.state); end
    checks++; if (bus.balance !== 32'd0) begin errors++; $display("FAIL rst_exec_balance: got %0h want 0", bus.balance); end
    checks++; if (bus.err !== 3'd0) begin errors++; $display("FAIL rst_exec_err: got %0d want 0", bus.err); end
    repeat (3) @(posedge clk);
    #1;
    card(4'd9);
    expect_done(1'b1, 3'd0, 32'd42, S_MENU); enter_pin(16'h9999); settle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL %s: no done, want err=%0d bal=%0h", tn, e.err, e.bal); end
      else begin
        o = obs_q.pop_front();
        if (o.ok !== e.ok || o.err !== e.err || o.bal !== e.bal || o.st !== e.st) begin
          errors++;
          $display("FAIL %s: got ok=%0d err=%0d bal=%0h st=%0d, want ok=%0d err=%0d bal=%0h st=%0d",
                   tn, o.ok, o.err, o.bal, o.st, e.ok, e.err, e.bal, e.st);
        end
      end
    end
  endtask

`ifdef SESSION_TIMEOUT_EN
  task automatic test_timeout();
    rec_t o;
    int menu_edge;
    obs_q.delete();
    do_op(LOGOUT, 32'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    obs_q.delete();
    card(4'd9);
    enter_pin(16'h9999);
    menu_edge = last_edge;
    for (int i = 0; i < 24; i++) begin
      if (obs_q.size() >= 2) break;
      @(posedge clk); #1;
    end
    checks++;
    if (obs_q.size() < 2) begin
      errors++; $display("FAIL timeout: got %0d done pulses want 2", obs_q.size());
    end else begin
      void'(obs_q.pop_front());
      o = obs_q.pop_front();
      if (o.ok !== 1'b0 || o.err !== 3'd7 || o.st !== S_IDLE || o.cyc != menu_edge + 16) begin
        errors++;
        $display("FAIL timeout: got ok=%0d err=%0d st=%0d edge=%0d, want ok=0 err=7 st=0 edge=%0d",
                 o.ok, o.err, o.st, o.cyc, menu_edge + 16);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_login();
    test_withdraw();
    test_ignored();
    test_deposit();
    test_lockout();
    test_change_pin();
    test_reset_mid_exec();
`ifdef SESSION_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
